// File: rtl/sample_pattern_sequencer.sv
// sample_pattern_sequencer: walks an N-bit counter from a seed for len steps.
// For each step it emits the raw value, its ones complement, its twos complement,
// or all three in turn (mode 3). Words leave through a valid/ready port.
//
// Handshake: a word transfers on any rising edge where tx_valid && tx_ready.
// Once tx_valid is high, tx_data and tx_valid hold until that transfer happens.
// tx_ready has no effect while tx_valid is low. All outputs come straight from
// flops, so there is no combinational path from tx_ready to tx_data or tx_valid.
module sample_pattern_sequencer #(
    parameter int N  = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [N-1:0]  seed,
    input  logic [LW-1:0] len,
    output logic [N-1:0]  tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PH_RAW  = 2'd0,
        PH_ONES = 2'd1,
        PH_TWOS = 2'd2
    } phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [N-1:0]  tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          hs;
    logic          step;
    logic          last;

    // Word for a counter value in a given phase; twos complement drops the carry.
    function automatic logic [N-1:0] word_of(input logic [N-1:0] c, input phase_e ph);
        logic [N-1:0] inv;
        inv = ~c;
        case (ph)
            PH_ONES: word_of = inv;
            PH_TWOS: word_of = inv + N'(1);
            default: word_of = c;
        endcase
    endfunction

    // Next-state, counter/phase bookkeeping and registered-output values.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        hs      = 1'b0;
        step    = (mode_q != 2'd3) || (phase_q == PH_TWOS);
        last    = step && (rem_q == LW'(1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    cnt_d  = seed;
                    rem_d  = len;
                    case (mode)
                        2'd1:    phase_d = PH_ONES;
                        2'd2:    phase_d = PH_TWOS;
                        default: phase_d = PH_RAW;
                    endcase
                    state_d = (len == '0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                hs = tx_valid_q && tx_ready;
                if (hs) begin
                    if (step) begin
                        cnt_d = cnt_q + N'(1);
                        rem_d = rem_q - LW'(1);
                        if (mode_q == 2'd3) begin
                            phase_d = PH_RAW;
                        end
                    end else begin
                        phase_d = (phase_q == PH_RAW) ? PH_ONES : PH_TWOS;
                    end
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_valid_d = (state_d == EMIT);
        busy_d     = (state_d == EMIT);
        done_d     = (state_d == DONE);
        tx_data_d  = (state_d == EMIT) ? word_of(cnt_d, phase_d) : '0;
    end

    // State and output registers; reset wins over everything and drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= PH_RAW;
            mode_q     <= 2'd0;
            cnt_q      <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
